// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//   Bank of NUM_CH independent, runtime-programmable clock dividers running off
//   SystemClk. Each channel produces a 50%-duty divided clock with a period of
//   2*div SystemClk cycles. It also produces a one-cycle tick strobe on every
//   rising edge of that divided clock.
//
// Optional feature (macro CLKDIV_SYNC_EN):
//   Adds the sync_in input. A pulse on sync_in restarts the phase of every
//   enabled channel. This lets the UART baud clock be aligned to a start-bit
//   edge.
//
// Ports:
//   SystemClk  in   sole clock, all state updates on posedge
//   reset      in   synchronous, active-high reset
//   wr_en      in   divisor write strobe
//   wr_ch      in   [2:0] channel index for the write (>= NUM_CH is ignored)
//   wr_div     in   [CNT_W-1:0] new divisor, 0 disables the channel
//   sync_in    in   phase restart for all enabled channels (CLKDIV_SYNC_EN only)
//   clk_o      out  [NUM_CH-1:0] divided clocks
//   tick_o     out  [NUM_CH-1:0] one-cycle strobe on each clk_o 0->1 edge
//   active_o   out  [NUM_CH-1:0] channel divisor is nonzero
//
// Write-port handshake: there is no back-pressure. A write is taken on every
// posedge where wr_en=1 and reset=0. The divisor is accepted only if wr_ch
// addresses an existing channel.
// -----------------------------------------------------------------------------
module clk_div_bank #(
  parameter int                        NUM_CH  = 2,
  parameter int                        CNT_W   = 16,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_RST = {16'd326, 16'd1}
) (
  input  logic              SystemClk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] active_o
);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] act_q, act_d;

  // Next-state logic. For each channel the order of precedence is:
  // a write to that channel, then the disabled hold, then the sync restart,
  // then normal counting. A write therefore swallows a terminal count that
  // falls in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;
      act_d[i]  = act_q[i];

      if (wr_en && (wr_ch == 3'(i))) begin
        div_d[i] = wr_div;
        cnt_d[i] = CNT_W'(1);
        clk_d[i] = 1'b0;
        act_d[i] = (wr_div != '0);
      end else if (div_q[i] == '0) begin
        cnt_d[i] = CNT_W'(1);
        clk_d[i] = 1'b0;
`ifdef CLKDIV_SYNC_EN
      end else if (sync_in) begin
        cnt_d[i] = CNT_W'(1);
        clk_d[i] = 1'b0;
`endif
      end else if (cnt_q[i] == div_q[i]) begin
        // The counter restarts at 1 and stops at div, so it never wraps.
        // This holds even when div is all-ones.
        clk_d[i]  = ~clk_q[i];
        cnt_d[i]  = CNT_W'(1);
        tick_d[i] = ~clk_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge SystemClk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= DIV_RST[i*CNT_W +: CNT_W];
        cnt_q[i]  <= CNT_W'(1);
        clk_q[i]  <= 1'b0;
        tick_q[i] <= 1'b0;
        act_q[i]  <= (DIV_RST[i*CNT_W +: CNT_W] != '0);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= div_d[i];
        cnt_q[i]  <= cnt_d[i];
        clk_q[i]  <= clk_d[i];
        tick_q[i] <= tick_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign clk_o    = clk_q;
  assign tick_o   = tick_q;
  assign active_o = act_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//   Bench for clk_div_bank with NUM_CH=2 and CNT_W=16. The reference model
//   records, for each channel, the divisor and the edge of its last phase
//   restart. Expected clk/tick values are derived arithmetically from the
//   number of edges since that restart.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

  localparam int          NUM_CH  = 2;
  localparam int          CNT_W   = 16;
  localparam logic [31:0] DIV_RST = {16'd326, 16'd1};

  // ---------------- clock / reset ----------------
  logic              SystemClk;
  logic              reset;
  logic              wr_en;
  logic [2:0]        wr_ch;
  logic [CNT_W-1:0]  wr_div;
`ifdef CLKDIV_SYNC_EN
  logic              sync_r;
`endif
  logic [NUM_CH-1:0] clk_o, tick_o, active_o;

  initial SystemClk = 1'b0;
  always #5 SystemClk = ~SystemClk;

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .SystemClk (SystemClk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_div    (wr_div),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_r),
`endif
    .clk_o     (clk_o),
    .tick_o    (tick_o),
    .active_o  (active_o)
  );

  // ---------------- scoreboard ----------------
  int unsigned total = 0;
  int unsigned bad   = 0;
  longint      cyc   = 0;
  logic [3*NUM_CH-1:0] exp_q[$];

  longint           m_t0  [NUM_CH];
  logic [CNT_W-1:0] m_div [NUM_CH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3*NUM_CH-1:0] model_out();
    logic [NUM_CH-1:0] c, t, a;
    longint n, d;
    for (int i = 0; i < NUM_CH; i++) begin
      n = cyc - m_t0[i];
      d = longint'(m_div[i]);
      a[i] = (d != 0);
      if (d == 0 || n == 0) begin
        c[i] = 1'b0;
        t[i] = 1'b0;
      end else begin
        c[i] = ((n / d) % 2) == 1;
        t[i] = (n % (2 * d)) == d;
      end
    end
    return {a, t, c};
  endfunction

  // ---------------- driver ----------------
  // Inputs are applied, one posedge is taken, the model is advanced, and then
  // the outputs are compared #1 after that edge.
  task automatic step(input bit rst, input bit we, input logic [2:0] ch,
                      input logic [CNT_W-1:0] dv, input bit sy);
    logic [3*NUM_CH-1:0] e;
    reset  = rst;
    wr_en  = we;
    wr_ch  = ch;
    wr_div = dv;
`ifdef CLKDIV_SYNC_EN
    sync_r = sy;
`endif
    @(posedge SystemClk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = DIV_RST[i*CNT_W +: CNT_W];
        m_t0[i]  = cyc;
      end
    end else begin
      if (we && int'(ch) < NUM_CH) begin
        m_div[ch] = dv;
        m_t0[ch]  = cyc;
      end
      if (sy)
        for (int i = 0; i < NUM_CH; i++)
          if (m_div[i] != 0) m_t0[i] = cyc;
    end
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    check("outputs{act,tick,clk}", 32'({active_o, tick_o, clk_o}), 32'(e));
    reset  = 1'b0;
    wr_en  = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync_r = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, '0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               rst;
    bit               we;
    logic [2:0]       ch;
    logic [CNT_W-1:0] dv;
    int               hold;
    logic [1:0]       exp_act;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int tick0_n, tick1_n, high1_n, first_rise, rise_gap;
    bit seen;
    reset  = 1'b1;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_r = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      m_t0[i]  = 0;
      m_div[i] = '0;
    end

    // Default divisors run for 1400 cycles after reset.
    step(1'b1, 1'b0, 3'd0, '0, 1'b0);
    check("reset_clk", 32'(clk_o), 32'h0);
    check("reset_tick", 32'(tick_o), 32'h0);
    check("reset_active", 32'(active_o), 32'h3);
    tick0_n = 0; tick1_n = 0; high1_n = 0; first_rise = -1;
    for (int k = 1; k <= 1400; k++) begin
      idle(1);
      tick0_n += int'(tick_o[0]);
      tick1_n += int'(tick_o[1]);
      high1_n += int'(clk_o[1]);
      if (clk_o[1] && first_rise < 0) first_rise = k;
    end
    check("ch1_first_rise", 32'(first_rise), 32'd326);
    check("ch1_tick_count", 32'(tick1_n), 32'd2);
    check("ch1_high_cycles", 32'(high1_n), 32'd652);
    check("ch0_tick_count", 32'(tick0_n), 32'd700);

    // Table-driven operations: each is applied and then held idle.
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 16'd0,     99, 2'b11};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 16'd3,     20, 2'b11};
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 16'd0,     50, 2'b10};
    vecs[3]  = '{1'b0, 1'b1, 3'd0, 16'd2,     20, 2'b11};
    vecs[4]  = '{1'b0, 1'b1, 3'd5, 16'd9,     10, 2'b11};
    vecs[5]  = '{1'b0, 1'b1, 3'd1, 16'd4,      9, 2'b11};
    vecs[6]  = '{1'b1, 1'b1, 3'd1, 16'd9,     30, 2'b11};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 16'hFFFF,   5, 2'b11};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 16'd0,      5, 2'b10};
    vecs[9]  = '{1'b0, 1'b1, 3'd1, 16'd0,      5, 2'b00};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 16'd0,      5, 2'b11};
    vecs[11] = '{1'b0, 1'b1, 3'd1, 16'd1,      8, 2'b11};
    for (int v = 0; v < 12; v++) begin
      step(vecs[v].rst, vecs[v].we, vecs[v].ch, vecs[v].dv, 1'b0);
      idle(vecs[v].hold);
      check($sformatf("vec%0d_active", v), 32'(active_o), 32'(vecs[v].exp_act));
    end

    // A write on the exact terminal-count cycle loses that toggle.
    step(1'b1, 1'b0, 3'd0, '0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 16'd5, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 3'd1, 16'd7, 1'b0);
    check("tc_write_clk1", 32'(clk_o[1]), 32'd0);
    check("tc_write_tick1", 32'(tick_o[1]), 32'd0);
    seen = 1'b0; rise_gap = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      idle(1);
      if (clk_o[1]) begin seen = 1'b1; rise_gap = k; end
    end
    check("tc_write_next_rise", 32'(rise_gap), 32'd7);

    // Out-of-range channel writes leave the outputs untouched.
    step(1'b0, 1'b1, 3'd7, 16'd3, 1'b0);
    idle(10);
    check("bad_ch_active", 32'(active_o), 32'h3);

`ifdef CLKDIV_SYNC_EN
    // A sync pulse at cnt=200 of ch1 restarts its phase.
    step(1'b1, 1'b0, 3'd0, '0, 1'b0);
    idle(199);
    step(1'b0, 1'b0, 3'd0, '0, 1'b1);
    check("sync_clk1", 32'(clk_o[1]), 32'd0);
    seen = 1'b0; rise_gap = 0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      idle(1);
      if (clk_o[1]) begin seen = 1'b1; rise_gap = k; end
    end
    check("sync_next_rise", 32'(rise_gap), 32'd326);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
